sha256_chain_core: RTL and testbench

Parametrised SHA-256 compression engine with multi-block chaining and configurable rounds per cycle. It is the next generation of the single-block hashing core in the mining datapath. It accepts one pre-padded 512-bit block per `go` handshake and either starts from the standard IV or chains from the previous digest. It presents a 256-bit digest with a one-cycle `done` pulse. An optional double-hash mode, SHA-256d, is provided for block-header mining.

---
 rtl/sha256_pkg.sv | 69 ++++++
 rtl/sha256_round.sv | 29 ++
 rtl/sha256_chain_core.sv | 159 +++++++++++++++
 tb/tb_sha256_chain_core.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 word and state types, round constants, IV and the
// bitwise helper functions shared by the round logic and the core.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ROUND  = 3'd1,
        S_FINAL  = 3'd2,
        S_ROUND2 = 3'd3,
        S_FINAL2 = 3'd4
    } state_t;

    // Working variables; a sits in the top word so a 256-bit hash maps directly.
    typedef struct packed {
        word_t a, b, c, d, e, f, g, h;
    } vars_t;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Wordwise 32-bit addition of two hashes, carries discarded per word.
    function automatic logic [255:0] hash_add(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        return r;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one purely combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  vars_t vars_in,
    input  word_t k,
    input  word_t w,
    output vars_t vars_out
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1 = vars_in.h + big_sigma1(vars_in.e) + ch(vars_in.e, vars_in.f, vars_in.g) + k + w;
        t2 = big_sigma0(vars_in.a) + maj(vars_in.a, vars_in.b, vars_in.c);
        vars_out = '{
            a: t1 + t2,
            b: vars_in.a,
            c: vars_in.b,
            d: vars_in.c,
            e: vars_in.d + t1,
            f: vars_in.e,
            g: vars_in.f,
            h: vars_in.g
        };
    end

endmodule

// File: rtl/sha256_chain_core.sv
// sha256_chain_core: SHA-256 compression with IV or chained start and
// ROUNDS_PER_CYCLE rounds per clock. Define SHA256D_EN to enable SHA-256d (dbl).
module sha256_chain_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         go,
    input  logic         first,
    input  logic         dbl,
    input  logic [511:0] sha_input,
    output logic         ready,
    output logic         done,
    output logic [255:0] sha_output
);

    localparam int         R        = ROUNDS_PER_CYCLE;
    localparam logic [6:0] R_STEP   = 7'(ROUNDS_PER_CYCLE);
    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_ROUND = S_ROUND;
    localparam logic [2:0] ST_FINAL = S_FINAL;

    if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
        $error("sha256_chain_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [2:0]            state;
    logic [6:0]            cnt;
    logic [0:15][31:0]     w;
    logic [0:15][31:0]     w_next;
    logic [0:15+R][31:0]   ext;
    logic [255:0]          base;
    vars_t                 work;
    vars_t                 stage [0:R];
    logic [255:0]          digest;
    logic                  in_round;
    logic                  last_step;

`ifdef SHA256D_EN
    localparam logic [2:0] ST_ROUND2 = S_ROUND2;
    localparam logic [2:0] ST_FINAL2 = S_FINAL2;
    logic dbl_q;
    assign in_round = (state == ST_ROUND) || (state == ST_ROUND2);
`else
    logic unused_dbl;
    assign unused_dbl = dbl;
    assign in_round = (state == ST_ROUND);
`endif

    assign ready     = (state == ST_IDLE);
    assign last_step = (cnt + R_STEP) == 7'd64;
    assign digest    = hash_add(base, work);

    // Rounds t..t+R-1 are chained combinationally within one clock.
    assign stage[0] = work;
    for (genvar i = 0; i < R; i++) begin : g_round
        logic [5:0] k_idx;
        assign k_idx = cnt[5:0] + 6'(i);
        sha256_round u_round (
            .vars_in  (stage[i]),
            .k        (K[k_idx]),
            .w        (w[i]),
            .vars_out (stage[i+1])
        );
    end

    // Window w holds W[t..t+15]; extend by R words, then shift by R.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        ext    = '0;
        w_next = '0;
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int j = 0; j < R; j++) begin
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
        end
        for (int i = 0; i < 16; i++) w_next[i] = ext[i+R];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            sha_output <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_ROUND;
                        cnt   <= '0;
                    end
                end
                ST_ROUND: begin
                    cnt <= cnt + R_STEP;
                    if (last_step) state <= ST_FINAL;
                end
                ST_FINAL: begin
                    cnt <= '0;
`ifdef SHA256D_EN
                    if (dbl_q) begin
                        state <= ST_ROUND2;
                    end else begin
                        sha_output <= digest;
                        done       <= 1'b1;
                        state      <= ST_IDLE;
                    end
`else
                    sha_output <= digest;
                    done       <= 1'b1;
                    state      <= ST_IDLE;
`endif
                end
`ifdef SHA256D_EN
                ST_ROUND2: begin
                    cnt <= cnt + R_STEP;
                    if (last_step) state <= ST_FINAL2;
                end
                ST_FINAL2: begin
                    cnt        <= '0;
                    sha_output <= digest;
                    done       <= 1'b1;
                    state      <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath is deliberately unreset; each job loads it on the accepting edge.
        if (state == ST_IDLE) begin
            if (go) begin
                w    <= sha_input;
                base <= first ? IV : sha_output;
                work <= first ? IV : sha_output;
`ifdef SHA256D_EN
                dbl_q <= dbl;
`endif
            end
        end else if (in_round) begin
            w    <= w_next;
            work <= stage[R];
        end
`ifdef SHA256D_EN
        else if (state == ST_FINAL && dbl_q) begin
            // Second block: first digest, one padding bit, length 256 bits.
            w    <= {digest, 32'h8000_0000, 192'h0, 32'h0000_0100};
            base <= IV;
            work <= IV;
        end
`endif
    end

endmodule

// File: tb/tb_sha256_chain_core.sv
// tb_sha256_chain_core: table-driven vectors over R=1/2/4 instances plus
// hand-written busy-go, mid-job reset and back-to-back sequences on the R=1 core.
module tb_sha256_chain_core;

    localparam logic [511:0] BLK_NUM  = {32'h31323334, 32'h35363738, 32'h39308000, 384'h0, 32'h00000050};
    localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_TWO0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO1 = {448'h0, 32'h00000000, 32'h000001c0};

    localparam logic [255:0] DIG_NUM = 256'hc775e7b757ede630cd0aa1113bd102661ab38829ca52a6422ab782862f268646;
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`ifdef SHA256D_EN
    localparam logic [255:0] DIG_DBL = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
    localparam bit           DBL_EN  = 1'b1;
`else
    localparam logic [255:0] DIG_DBL = DIG_ABC;
    localparam bit           DBL_EN  = 1'b0;
`endif

    localparam int RPC [3] = '{1, 2, 4};

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         dbl;
        logic         chk;
        logic [255:0] exp;
        string        name;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   go;
    logic         first;
    logic         dbl;
    logic [511:0] sha_input;
    logic [2:0]   ready;
    logic [2:0]   done;
    logic [255:0] dig [3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_chain_core #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .go(go[0]), .first(first), .dbl(dbl),
        .sha_input(sha_input), .ready(ready[0]), .done(done[0]), .sha_output(dig[0]));
    sha256_chain_core #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .go(go[1]), .first(first), .dbl(dbl),
        .sha_input(sha_input), .ready(ready[1]), .done(done[1]), .sha_output(dig[1]));
    sha256_chain_core #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .go(go[2]), .first(first), .dbl(dbl),
        .sha_input(sha_input), .ready(ready[2]), .done(done[2]), .sha_output(dig[2]));

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int k, input logic d);
        int single = 64 / RPC[k] + 1;
        return (d && DBL_EN) ? 2 * single : single;
    endfunction

    // Issue one job to all three cores and score latency, done count and digest.
    task automatic run_all(input vec_t v);
        int lat [3];
        int n_done [3];
        int window;
        for (int k = 0; k < 3; k++) begin
            lat[k]    = -1;
            n_done[k] = 0;
        end
        window    = exp_lat(0, v.dbl) + 4;
        sha_input = v.blk;
        first     = v.first;
        dbl       = v.dbl;
        @(negedge clk);
        go = 3'b111;
        @(posedge clk);
        #1;
        go = 3'b000;
        for (int k = 0; k < 3; k++)
            check($sformatf("%s r%0d ready_low", v.name, RPC[k]), 256'(ready[k]), 256'(0));
        for (int c = 1; c <= window; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (done[k]) begin
                    n_done[k]++;
                    if (lat[k] < 0) lat[k] = c;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s r%0d latency", v.name, RPC[k]), 256'(lat[k]), 256'(exp_lat(k, v.dbl)));
            check($sformatf("%s r%0d done_count", v.name, RPC[k]), 256'(n_done[k]), 256'(1));
            if (v.chk) check($sformatf("%s r%0d digest", v.name, RPC[k]), dig[k], v.exp);
        end
    endtask

    task automatic start1(input logic [511:0] blk, output int e0);
        sha_input = blk;
        first     = 1'b1;
        dbl       = 1'b0;
        @(negedge clk);
        go[0] = 1'b1;
        @(posedge clk);
        #1;
        go[0] = 1'b0;
        e0    = cyc;
    endtask

    task automatic wait_done1(input int budget, output int at);
        at = -1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (done[0]) begin
                at = cyc;
                break;
            end
        end
    endtask

    vec_t vecs [5];

    initial begin
        int e0, at1, at2;

        vecs[0] = '{BLK_NUM,  1'b1, 1'b0, 1'b1, DIG_NUM, "num"};
        vecs[1] = '{BLK_ABC,  1'b1, 1'b0, 1'b1, DIG_ABC, "abc"};
        vecs[2] = '{BLK_TWO0, 1'b1, 1'b0, 1'b0, '0,      "two_b0"};
        vecs[3] = '{BLK_TWO1, 1'b0, 1'b0, 1'b1, DIG_TWO, "two_b1"};
        vecs[4] = '{BLK_ABC,  1'b1, 1'b1, 1'b1, DIG_DBL, "abc_dbl"};

        reset_n   = 1'b0;
        go        = 3'b000;
        first     = 1'b0;
        dbl       = 1'b0;
        sha_input = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset r%0d ready", RPC[k]), 256'(ready[k]), 256'(1));
            check($sformatf("reset r%0d done", RPC[k]), 256'(done[k]), 256'(0));
            check($sformatf("reset r%0d sha_output", RPC[k]), dig[k], 256'h0);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_all(vecs[i]);

        // go while busy with a different block must be ignored.
        start1(BLK_ABC, e0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        sha_input = BLK_NUM;
        go[0]     = 1'b1;
        @(negedge clk);
        go[0] = 1'b0;
        wait_done1(80, at1);
        check("busy_go latency", 256'(at1 - e0), 256'(65));
        check("busy_go digest", dig[0], DIG_ABC);

        // Asynchronous abort at round 30, then a clean job.
        start1(BLK_NUM, e0);
        repeat (30) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort ready", 256'(ready[0]), 256'(1));
        check("abort done", 256'(done[0]), 256'(0));
        check("abort sha_output", dig[0], 256'h0);
        @(negedge clk);
        reset_n = 1'b1;
        start1(BLK_ABC, e0);
        wait_done1(80, at1);
        check("post_abort latency", 256'(at1 - e0), 256'(65));
        check("post_abort digest", dig[0], DIG_ABC);

        // Back-to-back: go raised in the done cycle is accepted on the next edge.
        start1(BLK_ABC, e0);
        wait_done1(80, at1);
        check("b2b first latency", 256'(at1 - e0), 256'(65));
        check("b2b first digest", dig[0], DIG_ABC);
        check("b2b ready in done cycle", 256'(ready[0]), 256'(1));
        sha_input = BLK_NUM;
        first     = 1'b1;
        go[0]     = 1'b1;
        @(posedge clk);
        #1;
        go[0] = 1'b0;
        e0    = cyc;
        check("b2b accepted", 256'(ready[0]), 256'(0));
        check("b2b accept edge", 256'(e0 - at1), 256'(1));
        wait_done1(80, at2);
        check("b2b second latency", 256'(at2 - e0), 256'(65));
        check("b2b second digest", dig[0], DIG_NUM);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
